// File: rtl/acc_requant_if.sv
// Handshake, configuration and status bundle for acc_requant.
// master = upstream/consumer side driving the stage, slave = acc_requant itself.
interface acc_requant_if #(
    parameter int D_W_ACC = 32,
    parameter int D_W_OUT = 8,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 6
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [D_W_ACC-1:0] in_data;
    logic signed [D_W_ACC-1:0] cfg_bias;
    logic signed [SCALE_W-1:0] cfg_scale;
    logic        [SHIFT_W-1:0] cfg_shift;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [D_W_OUT-1:0] out_data;
    logic                      sat_clr;
    logic        [15:0]        sat_count;

    modport master (
        output in_valid, in_data, cfg_bias, cfg_scale, cfg_shift, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, sat_count
    );

    modport slave (
        input  in_valid, in_data, cfg_bias, cfg_scale, cfg_shift, out_ready, sat_clr,
        output in_ready, out_valid, out_data, sat_count
    );
endinterface

// File: rtl/acc_requant.sv
// Accumulator drain stage: bias add, fixed-point scale, round/shift, saturate; 3-stage valid/ready pipe.
// Optional ReLU clamp at the output stage is enabled by defining ACC_REQUANT_RELU_EN.
module acc_requant #(
    parameter int D_W_ACC = 32,
    parameter int D_W_OUT = 8,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 6
) (
    input logic        clk,
    input logic        rst,
    acc_requant_if.slave bus
);
    localparam int B_W   = D_W_ACC + 1;
    localparam int P_W   = B_W + SCALE_W;
    localparam int R_W   = P_W + 1;
    localparam int MAX_S = P_W - 1;

    localparam logic signed [R_W-1:0] OMAX = {{(R_W-D_W_OUT+1){1'b0}}, {(D_W_OUT-1){1'b1}}};
    localparam logic signed [R_W-1:0] OMIN = {{(R_W-D_W_OUT+1){1'b1}}, {(D_W_OUT-1){1'b0}}};

    logic                      adv1, adv2, adv3;
    logic                      v1, v2, ov, sat3;
    logic signed [B_W-1:0]     b_nxt, b1;
    logic signed [SCALE_W-1:0] sc1;
    logic        [SHIFT_W-1:0] sh1, sh2;
    logic signed [P_W-1:0]     p2;
    logic signed [D_W_OUT-1:0] od, q;
    logic                      qsat;
    logic        [15:0]        cnt;
    logic        [31:0]        sh_w, s;
    logic signed [R_W-1:0]     pe, half, sum, r;

    assign adv3 = !ov | bus.out_ready;
    assign adv2 = !v2 | adv3;
    assign adv1 = !v1 | adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.sat_count = cnt;

    assign b_nxt = {bus.in_data[D_W_ACC-1], bus.in_data} + {bus.cfg_bias[D_W_ACC-1], bus.cfg_bias};

    // Rounding sum carries one extra bit: the largest product plus the half-LSB would otherwise wrap.
    always_comb begin
        sh_w = 32'(sh2);
        s    = (sh_w > 32'(MAX_S)) ? 32'(MAX_S) : sh_w;
        pe   = {p2[P_W-1], p2};
        half = '0;
        sum  = pe;
        r    = pe;
        if (s != 32'd0) begin
            half = R_W'(1) << (s - 32'd1);
            sum  = pe + half;
            r    = sum >>> s;
        end
    end

    always_comb begin
        q    = r[D_W_OUT-1:0];
        qsat = 1'b0;
`ifdef ACC_REQUANT_RELU_EN
        if (r[R_W-1]) begin
            q = '0;
        end else
`endif
        if (r > OMAX) begin
            q    = {1'b0, {(D_W_OUT-1){1'b1}}};
            qsat = 1'b1;
        end else if (r < OMIN) begin
            q    = {1'b1, {(D_W_OUT-1){1'b0}}};
            qsat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            ov   <= 1'b0;
            od   <= '0;
            sat3 <= 1'b0;
            cnt  <= '0;
        end else begin
            if (adv1) v1 <= bus.in_valid;
            if (adv2) v2 <= v1;
            if (adv3) begin
                ov <= v2;
                if (v2) begin
                    od   <= q;
                    sat3 <= qsat;
                end
            end
            if (bus.sat_clr)
                cnt <= '0;
            else if (ov && bus.out_ready && sat3 && cnt != '1)
                cnt <= cnt + 16'd1;
        end
    end

    // Datapath registers only need an enable; their validity is tracked by v1/v2.
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            b1  <= b_nxt;
            sc1 <= bus.cfg_scale;
            sh1 <= bus.cfg_shift;
        end
        if (adv2 && v1) begin
            p2  <= P_W'(b1) * P_W'(sc1);
            sh2 <= sh1;
        end
    end
endmodule

// File: tb/tb_acc_requant.sv
// Directed + random bench for acc_requant with a queue scoreboard and reference arithmetic model.
module tb_acc_requant;
    logic clk;
    logic rst;

    acc_requant_if #(.D_W_ACC(32), .D_W_OUT(8), .SCALE_W(16), .SHIFT_W(6)) bus ();

    acc_requant #(.D_W_ACC(32), .D_W_OUT(8), .SCALE_W(16), .SHIFT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] d;
        logic              s;
        int                c;
    } exp_t;

`ifdef ACC_REQUANT_RELU_EN
    localparam int T4_EXP = 0;
`else
    localparam int T4_EXP = -2;
`endif

    int                checks = 0;
    int                errors = 0;
    int                cyc    = 0;
    exp_t              sbq[$];
    logic [15:0]       sat_m  = '0;
    bit                acc_hs, out_hs, chk_lat;
    logic signed [7:0] last_out;

    function automatic exp_t model(input logic signed [31:0] d, input logic signed [31:0] bias,
                                   input logic signed [15:0] sc, input logic [5:0] sh, input int c);
        exp_t   e;
        longint b, p, r;
        int     s;
        b = longint'(d) + longint'(bias);
        p = b * longint'(sc);
        s = (int'(sh) > 48) ? 48 : int'(sh);
        if (s == 0) r = p;
        else        r = (p + (longint'(1) <<< (s - 1))) >>> s;
        e.c = c;
        e.s = 1'b0;
`ifdef ACC_REQUANT_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) begin
            e.d = 8'sd127; e.s = 1'b1;
        end else if (r < -128) begin
            e.d = -8'sd128; e.s = 1'b1;
        end else begin
            e.d = 8'(r);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score, then return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc_hs = bus.in_valid && bus.in_ready;
        out_hs = bus.out_valid && bus.out_ready;
        if (rst) begin
            sbq.delete();
            sat_m = '0;
        end else begin
            chk("sat_count", longint'(bus.sat_count), longint'(sat_m));
            if (out_hs) begin
                chk("spurious_out", longint'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("out_data", longint'(bus.out_data), longint'(e.d));
                    if (chk_lat) chk("latency", longint'(cyc - e.c), 3);
                    if (e.s && sat_m != 16'hFFFF) sat_m = sat_m + 16'd1;
                end
                last_out = bus.out_data;
            end
            if (bus.sat_clr) sat_m = '0;
            if (acc_hs) sbq.push_back(model(bus.in_data, bus.cfg_bias, bus.cfg_scale, bus.cfg_shift, cyc));
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc);
        for (int k = 0; k < maxc && sbq.size() != 0; k++) tick();
        chk("drain_empty", longint'(sbq.size()), 0);
    endtask

    task automatic send(input logic signed [31:0] d, input logic signed [31:0] bias,
                        input logic signed [15:0] sc, input logic [5:0] sh);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.cfg_bias  = bias;
        bus.cfg_scale = sc;
        bus.cfg_shift = sh;
        tick();
        chk("accepted", longint'(acc_hs), 1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int idx, nout, first, lastk;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_bias  = '0;
        bus.cfg_scale = '0;
        bus.cfg_shift = '0;
        bus.out_ready = 1'b0;
        bus.sat_clr   = 1'b0;
        chk_lat       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_sat_count", longint'(bus.sat_count), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 1);

        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        send(32'sd100, 32'sd0, 16'sd3, 6'd2);
        drain(10);
        chk_lat = 1'b0;
        chk("t1_out", longint'(last_out), 75);
        chk("t1_sat", longint'(bus.sat_count), 0);

        send(32'sd1000, 32'sd24, 16'sd1, 6'd3);
        drain(10);
        chk("t2_out", longint'(last_out), 127);
        chk("t2_sat", longint'(bus.sat_count), 1);

        send(-32'sd10, 32'sd0, 16'sd1, 6'd2);
        drain(10);
        chk("t3_out", longint'(last_out), T4_EXP);
        chk("t3_sat", longint'(bus.sat_count), 1);

        // Backpressure: three beats fill the pipe, then release and expect a gapless burst.
        bus.out_ready = 1'b0;
        bus.cfg_bias  = '0;
        bus.cfg_scale = 16'sd1;
        bus.cfg_shift = 6'd0;
        idx = 1;
        repeat (6) begin
            bus.in_valid = 1'b1;
            bus.in_data  = idx;
            tick();
            if (acc_hs) idx++;
        end
        chk("bp_accepts", longint'(idx - 1), 3);
        chk("bp_in_ready", longint'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        nout = 0; first = -1; lastk = -1;
        for (int k = 0; k < 20 && (idx <= 5 || sbq.size() != 0); k++) begin
            bus.in_valid = (idx <= 5);
            bus.in_data  = idx;
            tick();
            if (acc_hs) idx++;
            if (out_hs) begin
                if (first < 0) first = k;
                lastk = k;
                nout++;
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_count", longint'(nout), 5);
        chk("bp_span", longint'(lastk - first + 1), 5);
        chk("bp_last", longint'(last_out), 5);

        // Random traffic with per-beat configuration and random backpressure.
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 4000)) - 32'sd2000;
            bus.cfg_bias  = 32'($urandom_range(0, 200)) - 32'sd100;
            bus.cfg_scale = 16'($urandom);
            bus.cfg_shift = 6'($urandom_range(0, 63));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.sat_clr   = ($urandom_range(0, 63) == 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.sat_clr   = 1'b0;
        bus.out_ready = 1'b1;
        drain(20);

        // Reset with beats in flight.
        bus.out_ready = 1'b0;
        send(32'sd1000, 32'sd24, 16'sd1, 6'd0);
        send(32'sd7, 32'sd0, 16'sd1, 6'd0);
        send(32'sd9, 32'sd0, 16'sd1, 6'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
        chk("mid_rst_sat_count", longint'(bus.sat_count), 0);
        chk("mid_rst_in_ready", longint'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        repeat (6) tick();

        // Saturating counter: drive past 16'hFFFF, then clear on a saturated handshake.
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'sd1000;
        bus.cfg_bias  = 32'sd24;
        bus.cfg_scale = 16'sd1;
        bus.cfg_shift = 6'd0;
        repeat (65540) tick();
        bus.in_valid = 1'b0;
        drain(10);
        chk("sat_sticky", longint'(bus.sat_count), 65535);
        send(32'sd1000, 32'sd24, 16'sd1, 6'd0);
        for (int k = 0; k < 10; k++) begin
            bus.sat_clr = bus.out_valid;
            tick();
            if (out_hs) break;
        end
        bus.sat_clr = 1'b0;
        chk("sat_clr_hs", longint'(out_hs), 1);
        chk("sat_clr_prio", longint'(bus.sat_count), 0);
        drain(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
